// File: rtl/paging_pkg.sv
// Shared paging definitions: walker states, PDE/PTE bit positions, fault-code layout,
// the translation-cache entry and the U/W permission check used by the walker and the cache.
package paging_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ_PDE = 2'd1,
        READ_PTE = 2'd2,
        RESPOND  = 2'd3
    } walk_state_t;

    localparam int unsigned PTE_P_BIT = 32'd0;
    localparam int unsigned PTE_W_BIT = 32'd1;
    localparam int unsigned PTE_U_BIT = 32'd2;

    // x86 error-code bits 2:0
    typedef struct packed {
        logic user;
        logic write;
        logic present;
    } fault_code_t;

    typedef struct packed {
        logic        valid;
        logic [19:0] tag;
        logic [19:0] frame;
        logic        user;
        logic        write;
    } cache_entry_t;

    // Supervisor accesses are never refused on U/W.
    function automatic logic access_permitted(input logic user_mode, input logic write_access,
                                              input logic page_user, input logic page_write);
        return !user_mode || (page_user && (!write_access || page_write));
    endfunction

endpackage

// File: rtl/page_translation_cache.sv
// Single-entry translation cache keyed by LA[31:12]; built only with PAGE_TABLE_WALKER_CACHE_EN.
module page_translation_cache
    import paging_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        fill,
    input  logic [19:0] fill_tag,
    input  logic [19:0] fill_frame,
    input  logic        fill_user,
    input  logic        fill_write,
    input  logic [19:0] lookup_tag,
    output logic        hit,
    output logic [19:0] hit_frame,
    output logic        hit_user,
    output logic        hit_write
);

    cache_entry_t entry_r;

    // Entry storage: flush beats a fill arriving in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            entry_r <= '{valid: 1'b0, tag: 20'd0, frame: 20'd0, user: 1'b0, write: 1'b0};
        end else if (flush) begin
            entry_r <= '{valid: 1'b0, tag: 20'd0, frame: 20'd0, user: 1'b0, write: 1'b0};
        end else if (fill) begin
            entry_r <= '{valid: 1'b1, tag: fill_tag, frame: fill_frame,
                         user: fill_user, write: fill_write};
        end else begin
            entry_r <= entry_r;
        end
    end

    // A flush in the lookup cycle forces a miss.
    assign hit       = entry_r.valid && (entry_r.tag == lookup_tag) && !flush;
    assign hit_frame = entry_r.frame;
    assign hit_user  = entry_r.user;
    assign hit_write = entry_r.write;

endmodule

// File: rtl/page_table_walker.sv
// Two-level x86 (non-PAE) page table walker with bus timeout.
// Define PAGE_TABLE_WALKER_CACHE_EN to add a one-entry translation cache.
module page_table_walker
    import paging_pkg::*;
#(
    parameter int unsigned timeout_cycles = 32'd255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_vaild,
    output logic        o_ready,
    input  logic [31:0] i_linear_address,
    input  logic [31:0] i_page_directory_base,
    input  logic        i_write_enable,
    input  logic        i_user_mode,
    input  logic        i_flush,
    output logic [31:0] o_physical_address,
    output logic        o_page_fault,
    output logic [2:0]  o_fault_code,
    output logic        o_bus_error,
    output logic        o_mem_vaild,
    output logic [31:0] o_mem_address,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_data
);

    localparam int unsigned CNT_W = (timeout_cycles > 32'd1) ? $clog2(timeout_cycles) : 32'd1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(timeout_cycles - 32'd1);

    walk_state_t      state_r;
    logic [31:0]      la_r;
    logic             write_r;
    logic             user_r;
    logic             pde_u_r;
    logic             pde_w_r;
    logic [CNT_W-1:0] wait_cnt_r;

    logic             eff_u_s;
    logic             eff_w_s;
    logic             pte_fault_s;
    fault_code_t      pte_code_s;
    fault_code_t      pde_miss_code_s;
    logic             hit_s;
    logic             hit_ok_s;
    logic [19:0]      hit_frame_s;
    logic             hit_user_s;
    logic             hit_write_s;
    logic             unused_bits_s;

    assign unused_bits_s = ^{i_page_directory_base[11:0], i_mem_data[11:3]};

    // Permission evaluation of the returning PTE against the latched access.
    always_comb begin
        eff_u_s         = pde_u_r & i_mem_data[PTE_U_BIT];
        eff_w_s         = pde_w_r & i_mem_data[PTE_W_BIT];
        pde_miss_code_s = '{user: user_r, write: write_r, present: 1'b0};
        if (!i_mem_data[PTE_P_BIT]) begin
            pte_fault_s = 1'b1;
            pte_code_s  = '{user: user_r, write: write_r, present: 1'b0};
        end else if (!access_permitted(user_r, write_r, eff_u_s, eff_w_s)) begin
            pte_fault_s = 1'b1;
            pte_code_s  = '{user: user_r, write: write_r, present: 1'b1};
        end else begin
            pte_fault_s = 1'b0;
            pte_code_s  = '{user: 1'b0, write: 1'b0, present: 1'b0};
        end
    end

`ifdef PAGE_TABLE_WALKER_CACHE_EN
    logic fill_s;

    assign fill_s = (state_r == READ_PTE) && i_mem_ready && !pte_fault_s;

    page_translation_cache u_cache (
        .clock      (clock),
        .reset      (reset),
        .flush      (i_flush),
        .fill       (fill_s),
        .fill_tag   (la_r[31:12]),
        .fill_frame (i_mem_data[31:12]),
        .fill_user  (eff_u_s),
        .fill_write (eff_w_s),
        .lookup_tag (i_linear_address[31:12]),
        .hit        (hit_s),
        .hit_frame  (hit_frame_s),
        .hit_user   (hit_user_s),
        .hit_write  (hit_write_s)
    );
`else
    logic unused_flush_s;

    assign unused_flush_s = i_flush;
    assign hit_s          = 1'b0;
    assign hit_frame_s    = 20'd0;
    assign hit_user_s     = 1'b0;
    assign hit_write_s    = 1'b0;
`endif

    // A hit that would fault is walked so the fault comes from the live tables.
    always_comb begin
        hit_ok_s = hit_s && access_permitted(i_user_mode, i_write_enable, hit_user_s, hit_write_s);
    end

    // Walk FSM with all outputs registered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r            <= IDLE;
            la_r               <= 32'd0;
            write_r            <= 1'b0;
            user_r             <= 1'b0;
            pde_u_r            <= 1'b0;
            pde_w_r            <= 1'b0;
            wait_cnt_r         <= '0;
            o_ready            <= 1'b0;
            o_mem_vaild        <= 1'b0;
            o_mem_address      <= 32'd0;
            o_physical_address <= 32'd0;
            o_page_fault       <= 1'b0;
            o_fault_code       <= 3'b000;
            o_bus_error        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    o_ready <= 1'b0;
                    if (i_vaild) begin
                        la_r    <= i_linear_address;
                        write_r <= i_write_enable;
                        user_r  <= i_user_mode;
                        if (hit_ok_s) begin
                            state_r            <= RESPOND;
                            o_ready            <= 1'b1;
                            o_physical_address <= {hit_frame_s, i_linear_address[11:0]};
                            o_page_fault       <= 1'b0;
                            o_fault_code       <= 3'b000;
                            o_bus_error        <= 1'b0;
                        end else begin
                            state_r       <= READ_PDE;
                            wait_cnt_r    <= '0;
                            o_mem_vaild   <= 1'b1;
                            o_mem_address <= {i_page_directory_base[31:12],
                                              i_linear_address[31:22], 2'b00};
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                READ_PDE: begin
                    if (i_mem_ready) begin
                        wait_cnt_r <= '0;
                        if (!i_mem_data[PTE_P_BIT]) begin
                            state_r            <= RESPOND;
                            o_mem_vaild        <= 1'b0;
                            o_ready            <= 1'b1;
                            o_physical_address <= 32'd0;
                            o_page_fault       <= 1'b1;
                            o_fault_code       <= pde_miss_code_s;
                            o_bus_error        <= 1'b0;
                        end else begin
                            state_r       <= READ_PTE;
                            pde_u_r       <= i_mem_data[PTE_U_BIT];
                            pde_w_r       <= i_mem_data[PTE_W_BIT];
                            o_mem_address <= {i_mem_data[31:12], la_r[21:12], 2'b00};
                        end
                    end else if (wait_cnt_r == TIMEOUT_LAST) begin
                        state_r            <= RESPOND;
                        wait_cnt_r         <= '0;
                        o_mem_vaild        <= 1'b0;
                        o_ready            <= 1'b1;
                        o_physical_address <= 32'd0;
                        o_page_fault       <= 1'b0;
                        o_fault_code       <= 3'b000;
                        o_bus_error        <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(32'd1);
                    end
                end
                READ_PTE: begin
                    if (i_mem_ready) begin
                        state_r            <= RESPOND;
                        wait_cnt_r         <= '0;
                        o_mem_vaild        <= 1'b0;
                        o_ready            <= 1'b1;
                        o_physical_address <= {i_mem_data[31:12], la_r[11:0]};
                        o_page_fault       <= pte_fault_s;
                        o_fault_code       <= pte_code_s;
                        o_bus_error        <= 1'b0;
                    end else if (wait_cnt_r == TIMEOUT_LAST) begin
                        state_r            <= RESPOND;
                        wait_cnt_r         <= '0;
                        o_mem_vaild        <= 1'b0;
                        o_ready            <= 1'b1;
                        o_physical_address <= 32'd0;
                        o_page_fault       <= 1'b0;
                        o_fault_code       <= 3'b000;
                        o_bus_error        <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(32'd1);
                    end
                end
                RESPOND: begin
                    state_r <= IDLE;
                    o_ready <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    o_ready     <= 1'b0;
                    o_mem_vaild <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_page_table_walker.sv
// Directed self-checking bench for page_table_walker; expectations adapt to
// PAGE_TABLE_WALKER_CACHE_EN so the same bench covers both builds.
module tb_page_table_walker;

`ifdef PAGE_TABLE_WALKER_CACHE_EN
    localparam int HIT_LAT   = 1;
    localparam int HIT_READS = 0;
`else
    localparam int HIT_LAT   = 3;
    localparam int HIT_READS = 2;
`endif

    logic        clock;
    logic        reset;
    logic        i_vaild;
    logic        o_ready;
    logic [31:0] i_linear_address;
    logic [31:0] i_page_directory_base;
    logic        i_write_enable;
    logic        i_user_mode;
    logic        i_flush;
    logic [31:0] o_physical_address;
    logic        o_page_fault;
    logic [2:0]  o_fault_code;
    logic        o_bus_error;
    logic        o_mem_vaild;
    logic [31:0] o_mem_address;
    logic        i_mem_ready;
    logic [31:0] i_mem_data;

    logic [31:0] pde_val;
    logic [31:0] pte_val;
    logic        stall;

    int          total = 0;
    int          bad   = 0;
    int          lat_v;
    int          reads_v;
    logic [31:0] addr0_v;
    logic [31:0] addr1_v;
    logic        moved_v;

    page_table_walker dut (
        .clock                 (clock),
        .reset                 (reset),
        .i_vaild               (i_vaild),
        .o_ready               (o_ready),
        .i_linear_address      (i_linear_address),
        .i_page_directory_base (i_page_directory_base),
        .i_write_enable        (i_write_enable),
        .i_user_mode           (i_user_mode),
        .i_flush               (i_flush),
        .o_physical_address    (o_physical_address),
        .o_page_fault          (o_page_fault),
        .o_fault_code          (o_fault_code),
        .o_bus_error           (o_bus_error),
        .o_mem_vaild           (o_mem_vaild),
        .o_mem_address         (o_mem_address),
        .i_mem_ready           (i_mem_ready),
        .i_mem_data            (i_mem_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Zero-wait table memory holding one PDE and one PTE; stall withholds ready.
    assign i_mem_ready = o_mem_vaild & ~stall;
    always_comb begin
        if (o_mem_address == 32'h0010_0004) i_mem_data = pde_val;
        else if (o_mem_address == 32'h0020_0004) i_mem_data = pte_val;
        else i_mem_data = 32'h0000_0000;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request; lat_v counts cycles from the sampling edge to the o_ready cycle.
    task automatic run_req(input logic [31:0] la, input logic wr, input logic usr, input logic fl);
        logic [31:0] first_addr;
        logic        seen;
        @(negedge clock);
        i_vaild          = 1'b1;
        i_linear_address = la;
        i_write_enable   = wr;
        i_user_mode      = usr;
        i_flush          = fl;
        @(negedge clock);
        i_vaild = 1'b0;
        i_flush = 1'b0;
        lat_v   = 0;
        reads_v = 0;
        addr0_v = 32'd0;
        addr1_v = 32'd0;
        moved_v = 1'b0;
        seen    = 1'b0;
        first_addr = 32'd0;
        for (int k = 1; k <= 400; k++) begin
            if (o_mem_vaild) begin
                if (!seen) first_addr = o_mem_address;
                else if (!i_mem_ready && o_mem_address !== first_addr) moved_v = 1'b1;
                seen = 1'b1;
            end
            if (o_mem_vaild && i_mem_ready) begin
                if (reads_v == 0) addr0_v = o_mem_address;
                else addr1_v = o_mem_address;
                reads_v++;
                seen = 1'b0;
            end
            if (o_ready) begin
                lat_v = k;
                break;
            end
            @(negedge clock);
        end
    endtask

    initial begin
        reset                 = 1'b0;
        i_vaild               = 1'b0;
        i_linear_address      = 32'd0;
        i_page_directory_base = 32'h0010_0000;
        i_write_enable        = 1'b0;
        i_user_mode           = 1'b0;
        i_flush               = 1'b0;
        stall                 = 1'b0;
        pde_val               = 32'h0020_0007;
        pte_val               = 32'h0030_0007;
        repeat (3) @(negedge clock);
        check("rst_ready", {31'd0, o_ready}, 32'd0);
        check("rst_memvld", {31'd0, o_mem_vaild}, 32'd0);
        check("rst_memaddr", o_mem_address, 32'd0);
        check("rst_phys", o_physical_address, 32'd0);
        check("rst_flt", {28'd0, o_bus_error, o_fault_code}, 32'd0);
        check("rst_pf", {31'd0, o_page_fault}, 32'd0);
        reset = 1'b1;

        // Full miss walk
        run_req(32'h0040_1234, 1'b0, 1'b0, 1'b1);
        check("miss_lat", lat_v, 32'd3);
        check("miss_reads", reads_v, 32'd2);
        check("miss_a0", addr0_v, 32'h0010_0004);
        check("miss_a1", addr1_v, 32'h0020_0004);
        check("miss_phys", o_physical_address, 32'h0030_0234);
        check("miss_pf", {31'd0, o_page_fault}, 32'd0);
        check("miss_be", {31'd0, o_bus_error}, 32'd0);
        @(negedge clock);
        check("ready_pulse", {31'd0, o_ready}, 32'd0);
        repeat (3) @(negedge clock);
        check("hold_phys", o_physical_address, 32'h0030_0234);

        // Repeat same page: cache hit when enabled
        run_req(32'h0040_1FFC, 1'b0, 1'b0, 1'b0);
        check("hit_lat", lat_v, HIT_LAT);
        check("hit_reads", reads_v, HIT_READS);
        check("hit_phys", o_physical_address, 32'h0030_0FFC);
        run_req(32'h0040_1FFC, 1'b0, 1'b0, 1'b1);
        check("flush_lat", lat_v, 32'd3);
        check("flush_reads", reads_v, 32'd2);

        // PDE not present, user write
        pde_val = 32'h0020_0006;
        run_req(32'h0040_1234, 1'b1, 1'b1, 1'b1);
        check("pde_np_reads", reads_v, 32'd1);
        check("pde_np_pf", {31'd0, o_page_fault}, 32'd1);
        check("pde_np_code", {29'd0, o_fault_code}, 32'd6);

        // Read-only page
        pde_val = 32'h0020_0007;
        pte_val = 32'h0030_0005;
        run_req(32'h0040_1234, 1'b1, 1'b1, 1'b1);
        check("ro_user_pf", {31'd0, o_page_fault}, 32'd1);
        check("ro_user_code", {29'd0, o_fault_code}, 32'd7);
        run_req(32'h0040_1234, 1'b1, 1'b0, 1'b1);
        check("ro_sup_pf", {31'd0, o_page_fault}, 32'd0);
        check("ro_sup_phys", o_physical_address, 32'h0030_0234);
        run_req(32'h0040_1234, 1'b1, 1'b1, 1'b0);
        check("ro_refault_reads", reads_v, 32'd2);
        check("ro_refault_code", {28'd0, o_page_fault, o_fault_code}, 32'hF);
        run_req(32'h0040_1234, 1'b0, 1'b1, 1'b0);
        check("ro_uread_pf", {31'd0, o_page_fault}, 32'd0);
        check("ro_uread_reads", reads_v, HIT_READS);

        // PTE not present, supervisor read
        pte_val = 32'h0030_0006;
        run_req(32'h0040_1234, 1'b0, 1'b0, 1'b1);
        check("pte_np", {28'd0, o_page_fault, o_fault_code}, 32'h8);

        // Timeout on PDE read
        stall = 1'b1;
        run_req(32'h0040_1234, 1'b0, 1'b0, 1'b1);
        check("to_lat", lat_v, 32'd256);
        check("to_stable", {31'd0, moved_v}, 32'd0);
        check("to_be_pf", {30'd0, o_bus_error, o_page_fault}, 32'd2);
        check("to_memvld", {31'd0, o_mem_vaild}, 32'd0);
        @(negedge clock);
        check("to_idle", {30'd0, o_ready, o_mem_vaild}, 32'd0);
        stall = 1'b0;

        // Reset during READ_PTE
        pte_val = 32'h0030_0007;
        run_req(32'h0040_1234, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        i_vaild          = 1'b1;
        i_linear_address = 32'h0040_1234;
        i_flush          = 1'b1;
        @(negedge clock);
        i_vaild = 1'b0;
        i_flush = 1'b0;
        @(negedge clock);
        check("mid_in_pte", o_mem_address, 32'h0020_0004);
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst", {30'd0, o_ready, o_mem_vaild}, 32'd0);
        reset = 1'b1;
        run_req(32'h0040_1234, 1'b0, 1'b0, 1'b0);
        check("post_rst_reads", reads_v, 32'd2);
        check("post_rst_lat", lat_v, 32'd3);
        check("post_rst_phys", o_physical_address, 32'h0030_0234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
